uart_frame_dispatcher: RTL and testbench

Normal-mode dispatch stage between the SPI sine-index receiver and the bank of per-module `uart_tx` instances on the main FPGA. It accepts one validated `{sin_index, uart_id}` sample per frame and splits it into two UART bytes. It broadcasts both bytes to every inverter module in parallel, waits until all transmitters are idle, then issues a single shoot pulse that makes all modules apply the new switching state at the same time.

---
 rtl/uart_frame_dispatcher.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_frame_dispatcher.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_dispatcher.sv
// -----------------------------------------------------------------------------
// uart_frame_dispatcher
//
// Normal-mode dispatch stage between the SPI sine-index receiver and the bank
// of per-module uart_tx instances. Each accepted {sin_index, uart_id} sample is
// split into a HI byte {uart_id, sin_index[11:8]} and a LO byte sin_index[7:0].
// Both bytes are broadcast to every module. Once every transmitter is idle and
// a guard interval has elapsed, a single shoot pulse is issued so that all
// modules apply the new switching state together.
//
// Ports
//   clk          in   system clock (24 MHz)
//   reset        in   asynchronous, active-high reset
//   frame_valid  in   one-cycle strobe, sin_index/uart_id valid
//   sin_index    in   [11:0] sine table index
//   uart_id      in   [3:0]  target module 1..NUM_MODULES, 0 = broadcast
//   clear_err    in   clears the sticky error flags
//   ready        out  high in IDLE only
//   start_tx     out  [NUM_MODULES-1:0] per-UART start strobes
//   data_to_tx   out  [8*NUM_MODULES-1:0] byte for UART i at [8i+7:8i]
//   tx_busy      in   [NUM_MODULES-1:0] per-UART busy
//   shoot        out  shoot pulse, SHOOT_LEN cycles wide
//   frame_done   out  one-cycle strobe on the final shoot cycle
//   err_timeout  out  sticky, a transmitter wait exceeded TIMEOUT
//   err_overrun  out  sticky, frame_valid arrived while not ready
//   err_bad_id   out  sticky, uart_id > NUM_MODULES
//
// State table
//   state   | meaning
//   IDLE    | ready for a new sample
//   SEND_HI | HI byte presented, start_tx strobed
//   WAIT_HI | waiting for all transmitters to finish the HI byte
//   SEND_LO | LO byte presented, start_tx strobed
//   WAIT_LO | waiting for all transmitters to finish the LO byte
//   GUARD   | idle gap before the shoot pulse
//   SHOOT   | shoot pulse active
// -----------------------------------------------------------------------------
module uart_frame_dispatcher #(
    parameter int NUM_MODULES  = 9,
    parameter int GUARD_CYCLES = 48,
    parameter int SHOOT_LEN    = 24,
    parameter int TIMEOUT      = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_valid,
    input  logic [11:0]                sin_index,
    input  logic [3:0]                 uart_id,
    input  logic                       clear_err,
    output logic                       ready,
    output logic [NUM_MODULES-1:0]     start_tx,
    output logic [8*NUM_MODULES-1:0]   data_to_tx,
    input  logic [NUM_MODULES-1:0]     tx_busy,
    output logic                       shoot,
    output logic                       frame_done,
    output logic                       err_timeout,
    output logic                       err_overrun,
    output logic                       err_bad_id
);

    // One shared down-counter serves the transmitter wait, the guard gap and
    // the shoot width, since only one of them is ever running.
    localparam int TMR_MAX =
        (TIMEOUT > GUARD_CYCLES) ?
            ((TIMEOUT > SHOOT_LEN) ? TIMEOUT : SHOOT_LEN) :
            ((GUARD_CYCLES > SHOOT_LEN) ? GUARD_CYCLES : SHOOT_LEN);
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    // The strobe cycle counts as wait cycle 0, so the first WAIT cycle is
    // wait cycle 1; the counter hits zero on wait cycle TIMEOUT-1 and the
    // timeout becomes visible on wait cycle TIMEOUT.
    localparam logic [TMR_W-1:0] WAIT_LOAD  = TMR_W'(TIMEOUT - 2);
    localparam logic [TMR_W-1:0] GUARD_LOAD = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [TMR_W-1:0] SHOOT_LOAD = TMR_W'(SHOOT_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [3:0]       MAX_ID     = 4'(NUM_MODULES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_HI = 3'd1,
        WAIT_HI = 3'd2,
        SEND_LO = 3'd3,
        WAIT_LO = 3'd4,
        GUARD   = 3'd5,
        SHOOT   = 3'd6
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic             settle;
    logic [7:0]       lat_lo;

    logic             in_wait;
    logic             all_idle;
    logic             bad_id_evt;
    logic             overrun_evt;
    logic             timeout_evt;

    always_comb begin
        in_wait     = 1'b0;
        all_idle    = 1'b0;
        bad_id_evt  = 1'b0;
        overrun_evt = 1'b0;
        timeout_evt = 1'b0;

        in_wait  = (state == WAIT_HI) || (state == WAIT_LO);
        // The first WAIT cycle is the transmitter's start latency, so busy
        // is not trusted there.
        all_idle = in_wait && !settle && (tx_busy == '0);

        bad_id_evt  = (state == IDLE) && frame_valid && (uart_id > MAX_ID);
        overrun_evt = (state != IDLE) && frame_valid;
        timeout_evt = in_wait && !all_idle && (tmr == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tmr         <= '0;
            settle      <= 1'b0;
            lat_lo      <= '0;
            ready       <= 1'b1;
            start_tx    <= '0;
            data_to_tx  <= '0;
            shoot       <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_bad_id  <= 1'b0;
        end else begin
            start_tx   <= '0;
            frame_done <= 1'b0;

            // Sticky flags: a new event in the same cycle as clear_err wins.
            err_timeout <= timeout_evt | (err_timeout & ~clear_err);
            err_overrun <= overrun_evt | (err_overrun & ~clear_err);
            err_bad_id  <= bad_id_evt  | (err_bad_id  & ~clear_err);

            case (state)
                IDLE: begin
                    if (frame_valid && !bad_id_evt) begin
                        lat_lo     <= sin_index[7:0];
                        data_to_tx <= {NUM_MODULES{uart_id, sin_index[11:8]}};
                        start_tx   <= '1;
                        ready      <= 1'b0;
                        state      <= SEND_HI;
                    end
                end

                SEND_HI: begin
                    tmr    <= WAIT_LOAD;
                    settle <= 1'b1;
                    state  <= WAIT_HI;
                end

                WAIT_HI: begin
                    settle <= 1'b0;
                    if (all_idle) begin
                        data_to_tx <= {NUM_MODULES{lat_lo}};
                        start_tx   <= '1;
                        state      <= SEND_LO;
                    end else if (timeout_evt) begin
                        data_to_tx <= '0;
                        ready      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                SEND_LO: begin
                    tmr    <= WAIT_LOAD;
                    settle <= 1'b1;
                    state  <= WAIT_LO;
                end

                WAIT_LO: begin
                    settle <= 1'b0;
                    if (all_idle) begin
                        tmr   <= GUARD_LOAD;
                        state <= GUARD;
                    end else if (timeout_evt) begin
                        data_to_tx <= '0;
                        ready      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                GUARD: begin
                    if (tmr == '0) begin
                        tmr        <= SHOOT_LOAD;
                        shoot      <= 1'b1;
                        frame_done <= (SHOOT_LEN == 1);
                        state      <= SHOOT;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                SHOOT: begin
                    if (tmr == '0) begin
                        shoot      <= 1'b0;
                        data_to_tx <= '0;
                        ready      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        tmr        <= tmr - 1'b1;
                        // Raise frame_done so it lands on the last shoot cycle.
                        frame_done <= (tmr == TMR_ONE);
                    end
                end

                default: begin
                    shoot      <= 1'b0;
                    data_to_tx <= '0;
                    ready      <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_dispatcher.sv
module tb_uart_frame_dispatcher;

    localparam int N       = 9;
    localparam int GUARD   = 48;
    localparam int SLEN    = 24;
    localparam int TO      = 256;

    logic             clk;
    logic             reset;
    logic             frame_valid;
    logic [11:0]      sin_index;
    logic [3:0]       uart_id;
    logic             clear_err;
    logic             ready;
    logic [N-1:0]     start_tx;
    logic [8*N-1:0]   data_to_tx;
    logic [N-1:0]     tx_busy;
    logic             shoot;
    logic             frame_done;
    logic             err_timeout;
    logic             err_overrun;
    logic             err_bad_id;

    uart_frame_dispatcher #(
        .NUM_MODULES  (N),
        .GUARD_CYCLES (GUARD),
        .SHOOT_LEN    (SLEN),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .sin_index   (sin_index),
        .uart_id     (uart_id),
        .clear_err   (clear_err),
        .ready       (ready),
        .start_tx    (start_tx),
        .data_to_tx  (data_to_tx),
        .tx_busy     (tx_busy),
        .shoot       (shoot),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .err_bad_id  (err_bad_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter busy model: busy for busy_len cycles after a start strobe.
    int         busy_len [N];
    int         busy_cnt [N];
    logic [N-1:0] stuck;

    initial for (int i = 0; i < N; i++) busy_cnt[i] = 0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (start_tx[i]) busy_cnt[i] <= busy_len[i];
            else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
        end
    end

    always_comb begin
        tx_busy = '0;
        for (int i = 0; i < N; i++) tx_busy[i] = (busy_cnt[i] != 0) || stuck[i];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [71:0] act, logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] rep(logic [7:0] b);
        return {N{b}};
    endfunction

    typedef struct {
        bit         is_done;
        logic [7:0] b;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(bit is_done, logic [7:0] b);
        exp_t e;
        e.is_done = is_done;
        e.b       = b;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(logic [11:0] s, logic [3:0] id, bit full);
        push_exp(1'b0, {id, s[11:8]});
        if (full) begin
            push_exp(1'b0, s[7:0]);
            push_exp(1'b1, s[7:0]);
        end
    endtask

    // Monitor: consumes expected events whenever the DUT strobes an output.
    int           start_cnt     = 0;
    int           done_cnt      = 0;
    int           shoot_rises   = 0;
    int           shoot_w       = 0;
    int           last_start_cyc = 0;
    int           last_fall_cyc = 0;
    logic [N-1:0] prev_busy     = '0;
    logic         prev_shoot    = 1'b0;
    logic [N-1:0] ones_n        = '1;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_shoot = 1'b0;
            shoot_w    = 0;
        end else begin
            if (start_tx != '0) begin
                start_cnt++;
                last_start_cyc = cyc;
                check("start_all_channels", 72'(start_tx), 72'(ones_n));
                check("start_busy_before", 72'(prev_busy), 72'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start got=%0h want=none", start_tx);
                end else begin
                    e = exp_q.pop_front();
                    check("start_kind", 72'(e.is_done), 72'd0);
                    check("start_data", data_to_tx, rep(e.b));
                end
            end
            if (shoot && !prev_shoot) begin
                shoot_rises++;
                shoot_w = 0;
                check("shoot_gap", 72'(cyc - last_fall_cyc), 72'(GUARD + 1));
            end
            if (shoot) shoot_w++;
            if (frame_done) begin
                done_cnt++;
                check("done_in_shoot", 72'(shoot), 72'd1);
                check("shoot_width", 72'(shoot_w), 72'(SLEN));
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got=1 want=none");
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", 72'(e.is_done), 72'd1);
                    check("done_data", data_to_tx, rep(e.b));
                end
            end
            if (prev_busy != '0 && tx_busy == '0) last_fall_cyc = cyc;
            prev_busy  = tx_busy;
            prev_shoot = shoot;
        end
    end

    task automatic send(logic [11:0] s, logic [3:0] id);
        @(negedge clk);
        sin_index   = s;
        uart_id     = id;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic wait_done(string name, int budget);
        int n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 72'(frame_done === 1'b1), 72'd1);
        @(negedge clk);
        check({name, "_ready"}, 72'(ready), 72'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        reset       = 1'b1;
        frame_valid = 1'b0;
        sin_index   = '0;
        uart_id     = '0;
        clear_err   = 1'b0;
        stuck       = '0;
        for (int i = 0; i < N; i++) busy_len[i] = 10;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 72'(ready), 72'd1);
        check("rst_start", 72'(start_tx), 72'd0);
        check("rst_data", data_to_tx, 72'd0);
        check("rst_shoot", 72'(shoot), 72'd0);
        check("rst_done", 72'(frame_done), 72'd0);
        check("rst_errs", 72'({err_timeout, err_overrun, err_bad_id}), 72'd0);

        // Basic frame: 0x3A then 0x5C on all channels.
        push_frame(12'hA5C, 4'd3, 1'b1);
        send(12'hA5C, 4'd3);
        check("a_ready_low", 72'(ready), 72'd0);
        check("a_first_strobe", 72'(start_tx), 72'(ones_n));
        wait_done("a_done", 300);

        // Channel 5 slow: LO start must wait for it.
        busy_len[5] = 210;
        push_frame(12'h123, 4'd0, 1'b1);
        send(12'h123, 4'd0);
        wait_done("slow_done", 1000);
        busy_len[5] = 10;

        // Channel 0 stuck busy: timeout, no LO byte, no shoot. id=9 is the
        // largest accepted id.
        push_frame(12'h7FF, 4'd9, 1'b0);
        send(12'h7FF, 4'd9);
        stuck[0] = 1'b1;
        n = 0;
        while (err_timeout !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("to_flag", 72'(err_timeout), 72'd1);
        check("to_latency", 72'(cyc - last_start_cyc), 72'(TO));
        check("to_ready", 72'(ready), 72'd1);
        repeat (60) @(negedge clk);
        check("to_no_shoot", 72'(shoot_rises), 72'd2);
        stuck[0] = 1'b0;
        pulse_clear();
        check("to_cleared", 72'(err_timeout), 72'd0);

        // Bad id: flag set, nothing sent, ready stays high.
        send(12'hABC, 4'd12);
        check("bad_flag", 72'(err_bad_id), 72'd1);
        check("bad_ready", 72'(ready), 72'd1);
        pulse_clear();
        check("bad_cleared", 72'(err_bad_id), 72'd0);
        @(negedge clk);
        sin_index   = 12'h111;
        uart_id     = 4'd10;
        frame_valid = 1'b1;
        clear_err   = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        clear_err   = 1'b0;
        check("bad_set_wins", 72'(err_bad_id), 72'd1);
        pulse_clear();
        check("bad_cleared2", 72'(err_bad_id), 72'd0);

        // Overrun during GUARD: second frame dropped, first completes.
        push_frame(12'h456, 4'd1, 1'b1);
        s0 = start_cnt;
        send(12'h456, 4'd1);
        n = 0;
        while (start_cnt < s0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ovr_lo_sent", 72'(start_cnt), 72'(s0 + 2));
        repeat (20) @(negedge clk);
        send(12'hFFF, 4'd2);
        check("ovr_flag", 72'(err_overrun), 72'd1);
        wait_done("ovr_done", 200);

        // Reset in the middle of the shoot pulse.
        push_frame(12'h0F0, 4'd4, 1'b0);
        push_exp(1'b0, 8'hF0);
        send(12'h0F0, 4'd4);
        n = 0;
        while (shoot !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rs_shoot_seen", 72'(shoot), 72'd1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rs_shoot_async", 72'(shoot), 72'd0);
        check("rs_start", 72'(start_tx), 72'd0);
        check("rs_data", data_to_tx, 72'd0);
        check("rs_done", 72'(frame_done), 72'd0);
        check("rs_errs", 72'({err_timeout, err_overrun, err_bad_id}), 72'd0);
        check("rs_ready", 72'(ready), 72'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Normal frame after reset release.
        push_frame(12'h800, 4'd0, 1'b1);
        send(12'h800, 4'd0);
        check("post_ready_low", 72'(ready), 72'd0);
        wait_done("post_done", 300);

        repeat (5) @(negedge clk);
        check("end_queue_empty", 72'(exp_q.size()), 72'd0);
        check("end_starts", 72'(start_cnt), 72'd11);
        check("end_shoots", 72'(shoot_rises), 72'd5);
        check("end_dones", 72'(done_cnt), 72'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
